// File: rtl/cu_pkg.sv
// ---------------------------------------------------------------------------
// cu_pkg: shared definitions for the control-unit bubble stage.
//   - Control-word field widths/offsets (SRD at the MSB end, UB at bit 0)
//   - CW_DEFAULT : default control-word width (21)
//   - CU_NOP     : all-zero control word, used as the bubble/flush value
//   - bubble_state_t : stage FSM states
// ---------------------------------------------------------------------------
package cu_pkg;

    localparam int CW_DEFAULT = 21;

    // Field widths
    localparam int W_UB        = 1;
    localparam int W_ID_SR     = 2;
    localparam int W_RF_LE     = 1;
    localparam int W_L         = 1;
    localparam int W_RAM_CTRL  = 4;
    localparam int W_ALU_OP    = 4;
    localparam int W_SOH_OP    = 4;
    localparam int W_B         = 1;
    localparam int W_PSW_LE_RE = 2;
    localparam int W_SRD       = 1;

    // Field offsets (LSB position of each field)
    localparam int O_UB        = 0;
    localparam int O_ID_SR     = O_UB        + W_UB;
    localparam int O_RF_LE     = O_ID_SR     + W_ID_SR;
    localparam int O_L         = O_RF_LE     + W_RF_LE;
    localparam int O_RAM_CTRL  = O_L         + W_L;
    localparam int O_ALU_OP    = O_RAM_CTRL  + W_RAM_CTRL;
    localparam int O_SOH_OP    = O_ALU_OP    + W_ALU_OP;
    localparam int O_B         = O_SOH_OP    + W_SOH_OP;
    localparam int O_PSW_LE_RE = O_B         + W_B;
    localparam int O_SRD       = O_PSW_LE_RE + W_PSW_LE_RE;

    localparam logic [CW_DEFAULT-1:0] CU_NOP = '0;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } bubble_state_t;

endpackage

// File: rtl/cu_bubble_stage_if.sv
// ---------------------------------------------------------------------------
// cu_bubble_stage_if: control/handshake bundle for cu_bubble_stage.
//   master : drives ctrl_in, stall, bubble_req, bubble_len, flush;
//            observes ctrl_out, valid_out, busy, bubble_cnt
//   slave  : the stage itself (mirror directions)
// ---------------------------------------------------------------------------
interface cu_bubble_stage_if #(
    parameter int CW   = 21,
    parameter int MAXB = 3,
    parameter int CNTW = 16
);
    localparam int LW = $clog2(MAXB + 1);

    logic [CW-1:0]   ctrl_in;
    logic            stall;
    logic            bubble_req;
    logic [LW-1:0]   bubble_len;
    logic            flush;
    logic [CW-1:0]   ctrl_out;
    logic            valid_out;
    logic            busy;
    logic [CNTW-1:0] bubble_cnt;

    modport master (
        output ctrl_in, stall, bubble_req, bubble_len, flush,
        input  ctrl_out, valid_out, busy, bubble_cnt
    );

    modport slave (
        input  ctrl_in, stall, bubble_req, bubble_len, flush,
        output ctrl_out, valid_out, busy, bubble_cnt
    );
endinterface

// File: rtl/cu_bubble_stage_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter: W-bit up-counter that sticks at all-ones.
//   clk, rst_n : clock, async active-low reset (clears to 0)
//   en         : increment request
//   clr        : synchronous clear (wins over en)
//   q          : count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (en && (r_q != '1)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;
endmodule

// File: rtl/cu_bubble_stage.sv
// ---------------------------------------------------------------------------
// cu_bubble_stage: registered control-word stage between the control unit
// and ID/EX. Modes per edge, highest priority first: flush, stall,
// bubble insertion, pass.
//   clk, rst_n : clock, async active-low reset
//   bus        : cu_bubble_stage_if.slave
//                ctrl_in/stall/bubble_req/bubble_len/flush in,
//                ctrl_out/valid_out/busy/bubble_cnt out
// ---------------------------------------------------------------------------
import cu_pkg::*;

module cu_bubble_stage #(
    parameter int            CW       = CW_DEFAULT,
    parameter logic [CW-1:0] NOP_WORD = '0,
    parameter int            MAXB     = 3,
    parameter int            CNTW     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    cu_bubble_stage_if.slave   bus
);
    localparam int            LW     = $clog2(MAXB + 1);
    localparam logic [LW-1:0] MAXB_L = LW'(MAXB);

    bubble_state_t  r_state;
    logic [LW-1:0]  r_rem;
    logic [CW-1:0]  r_ctrl;
    logic           r_valid;

    logic [LW-1:0]  w_len;
    logic           w_adv;
    logic           w_start;
    logic           w_emit;
    logic [CNTW-1:0] w_cnt;

    assign w_len   = (bus.bubble_len > MAXB_L) ? MAXB_L : bus.bubble_len;
    assign w_adv   = !bus.flush && !bus.stall;
    // A zero-length request is just a pass.
    assign w_start = w_adv && (r_state == RUN) && bus.bubble_req && (w_len != '0);
    // Every NOP that comes from a bubble (not from flush) is counted.
    assign w_emit  = w_start || (w_adv && (r_state == BUBBLE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_rem   <= '0;
            r_ctrl  <= NOP_WORD;
            r_valid <= 1'b0;
        end else if (bus.flush) begin
            r_state <= RUN;
            r_rem   <= '0;
            r_ctrl  <= NOP_WORD;
            r_valid <= 1'b0;
        end else if (!bus.stall) begin
            case (r_state)
                RUN: begin
                    if (w_start) begin
                        r_ctrl  <= NOP_WORD;
                        r_valid <= 1'b0;
                        r_rem   <= w_len - 1'b1;
                        // Single-cycle bubbles never leave RUN, so busy stays low.
                        r_state <= (w_len > LW'(1)) ? BUBBLE : RUN;
                    end else begin
                        r_ctrl  <= bus.ctrl_in;
                        r_valid <= 1'b1;
                    end
                end
                BUBBLE: begin
                    r_ctrl  <= NOP_WORD;
                    r_valid <= 1'b0;
                    r_rem   <= r_rem - 1'b1;
                    if (r_rem <= LW'(1)) r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

    sat_counter #(.W(CNTW)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_emit),
        .clr   (1'b0),
        .q     (w_cnt)
    );

    assign bus.ctrl_out   = r_ctrl;
    assign bus.valid_out  = r_valid;
    assign bus.busy       = (r_state == BUBBLE);
    assign bus.bubble_cnt = w_cnt;
endmodule

// File: tb/tb_cu_bubble_stage.sv
module tb_cu_bubble_stage;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    // a: default build; b: MAXB=2 (clamp); c: CNTW=2 (saturation)
    cu_bubble_stage_if #(.CW(21), .MAXB(3), .CNTW(16)) ia ();
    cu_bubble_stage_if #(.CW(21), .MAXB(2), .CNTW(16)) ib ();
    cu_bubble_stage_if #(.CW(21), .MAXB(3), .CNTW(2))  ic ();

    cu_bubble_stage #(.CW(21), .NOP_WORD('0), .MAXB(3), .CNTW(16)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(ia.slave));
    cu_bubble_stage #(.CW(21), .NOP_WORD('0), .MAXB(2), .CNTW(16)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(ib.slave));
    cu_bubble_stage #(.CW(21), .NOP_WORD('0), .MAXB(3), .CNTW(2)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(ic.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ia.ctrl_in = '0; ia.stall = 0; ia.bubble_req = 0; ia.bubble_len = '0; ia.flush = 0;
        ib.ctrl_in = '0; ib.stall = 0; ib.bubble_req = 0; ib.bubble_len = '0; ib.flush = 0;
        ic.ctrl_in = '0; ic.stall = 0; ic.bubble_req = 0; ic.bubble_len = '0; ic.flush = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #12;
        tests++; if (ia.ctrl_out !== 21'h0) begin fails++; $display("FAIL reset_ctrl got %h exp 0", ia.ctrl_out); end
        tests++; if (ia.valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", ia.valid_out); end
        tests++; if (ia.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", ia.busy); end
        tests++; if (ia.bubble_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", ia.bubble_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_pass();
        apply_reset();
        ia.ctrl_in = 21'h1A5A5;
        step();
        tests++; if (ia.ctrl_out !== 21'h1A5A5) begin fails++; $display("FAIL pass_ctrl got %h exp 1a5a5", ia.ctrl_out); end
        tests++; if (ia.valid_out !== 1'b1) begin fails++; $display("FAIL pass_valid got %b exp 1", ia.valid_out); end
        tests++; if (ia.busy !== 1'b0) begin fails++; $display("FAIL pass_busy got %b exp 0", ia.busy); end
        // stall in RUN holds the previous word
        ia.ctrl_in = 21'h00FFF;
        ia.stall = 1;
        step();
        tests++; if (ia.ctrl_out !== 21'h1A5A5) begin fails++; $display("FAIL run_stall_ctrl got %h exp 1a5a5", ia.ctrl_out); end
        ia.stall = 0;
        step();
        tests++; if (ia.ctrl_out !== 21'h00FFF) begin fails++; $display("FAIL pass2_ctrl got %h exp 00fff", ia.ctrl_out); end
    endtask

    task automatic test_bubble3();
        logic [1:0] exp_busy [1:3];
        exp_busy[1] = 1; exp_busy[2] = 1; exp_busy[3] = 0;
        apply_reset();
        ia.ctrl_in = 21'h12345;
        ia.bubble_req = 1; ia.bubble_len = 2'd3;
        for (int c = 1; c <= 3; c++) begin
            step();
            ia.bubble_req = 0; ia.bubble_len = '0;
            tests++; if (ia.ctrl_out !== 21'h0 || ia.valid_out !== 1'b0) begin fails++; $display("FAIL bub3_nop cyc %0d got %h/%b exp 0/0", c, ia.ctrl_out, ia.valid_out); end
            tests++; if (ia.busy !== exp_busy[c][0]) begin fails++; $display("FAIL bub3_busy cyc %0d got %b exp %b", c, ia.busy, exp_busy[c][0]); end
            tests++; if (ia.bubble_cnt !== 16'(c)) begin fails++; $display("FAIL bub3_cnt cyc %0d got %0d exp %0d", c, ia.bubble_cnt, c); end
        end
        step();
        tests++; if (ia.ctrl_out !== 21'h12345 || ia.valid_out !== 1'b1) begin fails++; $display("FAIL bub3_resume got %h/%b exp 12345/1", ia.ctrl_out, ia.valid_out); end
    endtask

    task automatic test_stall_in_bubble();
        apply_reset();
        ia.ctrl_in = 21'h0BEEF;
        ia.bubble_req = 1; ia.bubble_len = 2'd2;
        step();
        ia.bubble_req = 0; ia.bubble_len = '0;
        tests++; if (ia.busy !== 1'b1 || ia.bubble_cnt !== 16'd1) begin fails++; $display("FAIL stb_first got busy %b cnt %0d exp 1/1", ia.busy, ia.bubble_cnt); end
        ia.stall = 1;
        for (int c = 0; c < 2; c++) begin
            step();
            tests++; if (ia.ctrl_out !== 21'h0 || ia.busy !== 1'b1 || ia.bubble_cnt !== 16'd1) begin fails++; $display("FAIL stb_hold got %h busy %b cnt %0d exp 0/1/1", ia.ctrl_out, ia.busy, ia.bubble_cnt); end
        end
        ia.stall = 0;
        step();
        tests++; if (ia.ctrl_out !== 21'h0 || ia.busy !== 1'b0 || ia.bubble_cnt !== 16'd2) begin fails++; $display("FAIL stb_second got %h busy %b cnt %0d exp 0/0/2", ia.ctrl_out, ia.busy, ia.bubble_cnt); end
        step();
        tests++; if (ia.ctrl_out !== 21'h0BEEF || ia.valid_out !== 1'b1) begin fails++; $display("FAIL stb_resume got %h/%b exp 0beef/1", ia.ctrl_out, ia.valid_out); end
    endtask

    task automatic test_flush_stall();
        apply_reset();
        ia.ctrl_in = 21'h0ABCD;
        ia.bubble_req = 1; ia.bubble_len = 2'd3;
        step();
        ia.bubble_req = 0; ia.bubble_len = '0;
        ia.flush = 1; ia.stall = 1;
        step();
        tests++; if (ia.ctrl_out !== 21'h0 || ia.valid_out !== 1'b0 || ia.busy !== 1'b0) begin fails++; $display("FAIL flush_out got %h/%b busy %b exp 0/0/0", ia.ctrl_out, ia.valid_out, ia.busy); end
        tests++; if (ia.bubble_cnt !== 16'd1) begin fails++; $display("FAIL flush_cnt got %0d exp 1", ia.bubble_cnt); end
        ia.flush = 0; ia.stall = 0;
        step();
        tests++; if (ia.ctrl_out !== 21'h0ABCD || ia.valid_out !== 1'b1) begin fails++; $display("FAIL flush_resume got %h/%b exp 0abcd/1", ia.ctrl_out, ia.valid_out); end
    endtask

    task automatic test_clamp_zero();
        apply_reset();
        ia.ctrl_in = 21'h15555;
        ia.bubble_req = 1; ia.bubble_len = 2'd0;
        step();
        ia.bubble_req = 0;
        tests++; if (ia.ctrl_out !== 21'h15555 || ia.valid_out !== 1'b1 || ia.bubble_cnt !== 16'd0) begin fails++; $display("FAIL zero_len got %h/%b cnt %0d exp 15555/1/0", ia.ctrl_out, ia.valid_out, ia.bubble_cnt); end
        // MAXB=2 build, request of 3 is clamped to 2
        ib.ctrl_in = 21'h1C0DE;
        ib.bubble_req = 1; ib.bubble_len = 2'd3;
        step();
        ib.bubble_req = 0; ib.bubble_len = '0;
        tests++; if (ib.ctrl_out !== 21'h0 || ib.busy !== 1'b1) begin fails++; $display("FAIL clamp_c1 got %h busy %b exp 0/1", ib.ctrl_out, ib.busy); end
        step();
        tests++; if (ib.ctrl_out !== 21'h0 || ib.busy !== 1'b0 || ib.bubble_cnt !== 16'd2) begin fails++; $display("FAIL clamp_c2 got %h busy %b cnt %0d exp 0/0/2", ib.ctrl_out, ib.busy, ib.bubble_cnt); end
        step();
        tests++; if (ib.ctrl_out !== 21'h1C0DE || ib.valid_out !== 1'b1) begin fails++; $display("FAIL clamp_resume got %h/%b exp 1c0de/1", ib.ctrl_out, ib.valid_out); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [0:4];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        apply_reset();
        ic.ctrl_in = 21'h00001;
        for (int i = 0; i < 5; i++) begin
            ic.bubble_req = 1; ic.bubble_len = 2'd1;
            step();
            ic.bubble_req = 0; ic.bubble_len = '0;
            tests++; if (ic.bubble_cnt !== exp_cnt[i] || ic.busy !== 1'b0 || ic.valid_out !== 1'b0) begin fails++; $display("FAIL sat_%0d got cnt %0d busy %b valid %b exp %0d/0/0", i, ic.bubble_cnt, ic.busy, ic.valid_out, exp_cnt[i]); end
            step();
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        ia.ctrl_in = 21'h1F00F;
        ia.bubble_req = 1; ia.bubble_len = 2'd3;
        step();
        ia.bubble_req = 0; ia.bubble_len = '0;
        tests++; if (ia.busy !== 1'b1 || ia.bubble_cnt !== 16'd1) begin fails++; $display("FAIL ar_pre got busy %b cnt %0d exp 1/1", ia.busy, ia.bubble_cnt); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (ia.busy !== 1'b0 || ia.bubble_cnt !== 16'd0 || ia.valid_out !== 1'b0 || ia.ctrl_out !== 21'h0) begin fails++; $display("FAIL ar_now got busy %b cnt %0d valid %b ctrl %h exp 0/0/0/0", ia.busy, ia.bubble_cnt, ia.valid_out, ia.ctrl_out); end
        #1 rst_n = 1'b1;
        step();
        tests++; if (ia.ctrl_out !== 21'h1F00F || ia.valid_out !== 1'b1 || ia.busy !== 1'b0) begin fails++; $display("FAIL ar_after got %h/%b busy %b exp 1f00f/1/0", ia.ctrl_out, ia.valid_out, ia.busy); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_pass();
        test_bubble3();
        test_stall_in_bubble();
        test_flush_stall();
        test_clamp_zero();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
